// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: interval-timer register map, control bits and sequencer states
package timer_regs_pkg;

   localparam logic [2:0] TMR_STATUS  = 3'd0;
   localparam logic [2:0] TMR_CONTROL = 3'd1;
   localparam logic [2:0] TMR_PERL    = 3'd2;
   localparam logic [2:0] TMR_PERH    = 3'd3;
   localparam logic [2:0] TMR_SNAPL   = 3'd4;
   localparam logic [2:0] TMR_SNAPH   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      IDLE,
      WR_PL,
      WR_PH,
      WR_CTRL,
      RUN,
      CLR_ST,
      SNAP,
      RD_L,
      RD_H,
      UPD,
      WR_STOP
   } seq_state_t;

   function automatic logic [15:0] ctrl_word(input logic stop_b, input logic start_b,
                                             input logic cont_b, input logic ito_b);
      logic [15:0] w;
      w = '0;
      w[CTRL_STOP]  = stop_b;
      w[CTRL_START] = start_b;
      w[CTRL_CONT]  = cont_b;
      w[CTRL_ITO]   = ito_b;
      return w;
   endfunction

endpackage

// File: rtl/avm_single_access.sv
// avm_single_access: issues one single-cycle Avalon-MM read or write and reports done plus read data
module avm_single_access #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        wr,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic        done,
   output logic [15:0] rdata,
   output logic [2:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [15:0] avm_writedata,
   input  logic [15:0] avm_readdata
);

   logic       rd_wait;
   logic [7:0] lat;

   // One chipselect cycle per request; reads wait out the slave latency before capturing data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= '0;
         done           <= 1'b0;
         rdata          <= '0;
         rd_wait        <= 1'b0;
         lat            <= '0;
      end else begin
         done           <= 1'b0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= '0;
         if (req) begin
            avm_chipselect <= 1'b1;
            avm_address    <= addr;
            avm_write_n    <= !wr;
            avm_writedata  <= wr ? wdata : '0;
         end else if (avm_chipselect && !avm_write_n) begin
            done <= 1'b1;
         end else if (avm_chipselect && READ_LATENCY == 0) begin
            rdata <= avm_readdata;
            done  <= 1'b1;
         end else if (avm_chipselect) begin
            rd_wait <= 1'b1;
            lat     <= 8'(READ_LATENCY - 1);
         end else if (rd_wait && lat == '0) begin
            rdata   <= avm_readdata;
            done    <= 1'b1;
            rd_wait <= 1'b0;
         end else if (rd_wait) begin
            lat <= lat - 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_avalon_master_seq.sv
// timer_avalon_master_seq: programs the interval timer and services each timeout over Avalon-MM
module timer_avalon_master_seq
   import timer_regs_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int TICK_W       = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       period_in,
   input  logic              continuous,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              timer_irq,
   output logic              busy,
   output logic              tick_pulse,
   output logic [TICK_W-1:0] tick_count,
   output logic [31:0]       snapshot,
   output logic              snapshot_valid,
   output logic              err
);

   seq_state_t  state;
   logic [31:0] period;
   logic        cont;
   logic        stop_lat;
   logic        pend;
   logic [15:0] snap_lo;
   logic        acc_state;
   logic        acc_req;
   logic        acc_wr;
   logic [2:0]  acc_addr;
   logic [15:0] acc_wdata;
   logic        acc_done;
   logic [15:0] acc_rdata;

   assign busy = state != IDLE;

   // Bus access owed by the current state; requested once, then held off until done
   always_comb begin
      acc_state = state inside {WR_PL, WR_PH, WR_CTRL, CLR_ST, SNAP, RD_L, RD_H, WR_STOP};
      acc_req   = acc_state && !pend;
      acc_wr    = !(state inside {RD_L, RD_H});
      acc_addr  = state == WR_PL                        ? TMR_PERL    :
                  state == WR_PH                        ? TMR_PERH    :
                  state == WR_CTRL || state == WR_STOP  ? TMR_CONTROL :
                  state == CLR_ST                       ? TMR_STATUS  :
                  state == RD_H                         ? TMR_SNAPH   : TMR_SNAPL;
      acc_wdata = state == WR_PL   ? period[15:0]                      :
                  state == WR_PH   ? period[31:16]                     :
                  state == WR_CTRL ? ctrl_word(1'b0, 1'b1, cont, 1'b1) :
                  state == WR_STOP ? ctrl_word(1'b1, 1'b0, 1'b0, 1'b0) : '0;
   end

   avm_single_access #(.READ_LATENCY(READ_LATENCY)) u_acc (
      .clk           (clk),
      .reset_n       (reset_n),
      .req           (acc_req),
      .wr            (acc_wr),
      .addr          (acc_addr),
      .wdata         (acc_wdata),
      .done          (acc_done),
      .rdata         (acc_rdata),
      .avm_address   (avm_address),
      .avm_chipselect(avm_chipselect),
      .avm_write_n   (avm_write_n),
      .avm_writedata (avm_writedata),
      .avm_readdata  (avm_readdata)
   );

   // Sequencer: program period/control, service each timeout, handle stop requests
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         period         <= '0;
         cont           <= 1'b0;
         stop_lat       <= 1'b0;
         pend           <= 1'b0;
         snap_lo        <= '0;
         tick_pulse     <= 1'b0;
         tick_count     <= '0;
         snapshot       <= '0;
         snapshot_valid <= 1'b0;
         err            <= 1'b0;
      end else begin
         tick_pulse     <= 1'b0;
         snapshot_valid <= 1'b0;
         err            <= 1'b0;
         if (acc_req)
            pend <= 1'b1;
         if (acc_done)
            pend <= 1'b0;
         if (acc_done && state == RD_L)
            snap_lo <= acc_rdata;
         if (stop && state inside {CLR_ST, SNAP, RD_L, RD_H, UPD})
            stop_lat <= 1'b1;
         case (state)
            IDLE: begin
               if (start && period_in == '0) begin
                  err <= 1'b1;
               end else if (start) begin
                  period     <= period_in;
                  cont       <= continuous;
                  tick_count <= '0;
                  stop_lat   <= 1'b0;
                  state      <= WR_PL;
               end
            end
            WR_PL:   if (acc_done) state <= WR_PH;
            WR_PH:   if (acc_done) state <= WR_CTRL;
            WR_CTRL: if (acc_done) state <= RUN;
            RUN: begin
               if (stop)
                  state <= WR_STOP;
               else if (timer_irq)
                  state <= CLR_ST;
            end
            CLR_ST:  if (acc_done) state <= SNAP;
            SNAP:    if (acc_done) state <= RD_L;
            RD_L:    if (acc_done) state <= RD_H;
            RD_H:    if (acc_done) state <= UPD;
            UPD: begin
               tick_pulse     <= 1'b1;
               snapshot_valid <= 1'b1;
               tick_count     <= tick_count + 1'b1;
               snapshot       <= {acc_rdata, snap_lo};
               stop_lat       <= 1'b0;
               state          <= (stop_lat || stop) ? WR_STOP : cont ? RUN : IDLE;
            end
            WR_STOP: if (acc_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_avalon_master_seq.sv
// tb_timer_avalon_master_seq: directed bench with an interval-timer slave model and bus scoreboard
module tb_timer_avalon_master_seq;

   typedef struct {
      logic [2:0]  a;
      logic        w;
      logic [15:0] d;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, stop, continuous;
   logic [31:0] period_in;
   logic [2:0]  avm_address;
   logic        avm_chipselect, avm_write_n;
   logic [15:0] avm_writedata, avm_readdata;
   logic        timer_irq, busy, tick_pulse, snapshot_valid, err;
   logic [31:0] tick_count, snapshot;

   int          total = 0;
   int          bad = 0;
   bus_t        exp_q[$];
   logic [31:0] snap_q[$];
   bus_t        e;
   logic [31:0] exp_ticks;
   logic        force_rd;

   logic        m_to, m_run, m_ito, m_cont;
   logic [31:0] m_per, m_cnt, m_snap;
   logic [15:0] m_rd;

   always #5 clk = ~clk;

   timer_avalon_master_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period_in(period_in),
      .continuous(continuous), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .timer_irq(timer_irq), .busy(busy), .tick_pulse(tick_pulse), .tick_count(tick_count),
      .snapshot(snapshot), .snapshot_valid(snapshot_valid), .err(err)
   );

   // Interval-timer slave: down-counter, timeout flag, snapshot latch, registered readdata
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_to <= 0; m_run <= 0; m_ito <= 0; m_cont <= 0;
         m_per <= 0; m_cnt <= 0; m_snap <= 0; m_rd <= 0;
      end else begin
         if (m_run) begin
            if (m_cnt == 0) begin
               m_to  <= 1'b1;
               m_cnt <= m_per;
               if (!m_cont) m_run <= 1'b0;
            end else m_cnt <= m_cnt - 1;
         end
         if (avm_chipselect && !avm_write_n) begin
            case (avm_address)
               3'd0: m_to <= 1'b0;
               3'd1: begin
                  m_ito  <= avm_writedata[0];
                  m_cont <= avm_writedata[1];
                  if (avm_writedata[2]) begin m_run <= 1'b1; m_cnt <= m_per; end
                  if (avm_writedata[3]) m_run <= 1'b0;
               end
               3'd2: m_per[15:0] <= avm_writedata;
               3'd3: m_per[31:16] <= avm_writedata;
               3'd4, 3'd5: m_snap <= m_cnt;
               default: ;
            endcase
         end
         if (avm_chipselect && avm_write_n)
            m_rd <= force_rd ? (avm_address == 3'd4 ? 16'h1234 : 16'h0056) :
                    avm_address == 3'd4 ? m_snap[15:0] :
                    avm_address == 3'd5 ? m_snap[31:16] :
                    avm_address == 3'd0 ? {14'd0, m_run, m_to} : 16'd0;
      end
   end
   assign avm_readdata = m_rd;
   assign timer_irq    = m_to & m_ito;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Bus monitor: every access must match the next expected transaction
   always @(negedge clk) begin
      if (reset_n && avm_chipselect) begin
         chk("bus_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bus_addr", 32'(avm_address), 32'(e.a));
            chk("bus_write", 32'(!avm_write_n), 32'(e.w));
            if (e.w) chk("bus_wdata", 32'(avm_writedata), 32'(e.d));
         end
         if (!avm_write_n && avm_address == 3'd4)
            snap_q.push_back(force_rd ? 32'h0056_1234 : m_cnt);
      end
   end

   task automatic push_bus(input logic [2:0] a, input logic w, input logic [15:0] d);
      exp_q.push_back('{a: a, w: w, d: d});
   endtask

   task automatic push_prog(input logic [31:0] p, input logic c);
      push_bus(3'd2, 1'b1, p[15:0]);
      push_bus(3'd3, 1'b1, p[31:16]);
      push_bus(3'd1, 1'b1, {13'd0, 1'b1, c, 1'b1});
   endtask

   task automatic push_service();
      push_bus(3'd0, 1'b1, 16'd0);
      push_bus(3'd4, 1'b1, 16'd0);
      push_bus(3'd4, 1'b0, 16'd0);
      push_bus(3'd5, 1'b0, 16'd0);
   endtask

   task automatic pulse_start(input logic [31:0] p, input logic c);
      period_in  = p;
      continuous = c;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk) stop = 1'b0;
   endtask

   task automatic wait_for(input int kind, input string tag, input int lim);
      bit hit = 0;
      for (int i = 0; i < lim && !hit; i++) begin
         @(negedge clk);
         hit = kind == 0 ? snapshot_valid :
               kind == 1 ? !busy :
               kind == 2 ? (avm_chipselect && avm_write_n && avm_address == 3'd4) :
                           (avm_chipselect && !avm_write_n && avm_address == 3'd3);
      end
      chk(tag, 32'(hit), 1);
   endtask

   task automatic check_upd(input string tag);
      exp_ticks++;
      chk({tag, "_tick_pulse"}, 32'(tick_pulse), 1);
      chk({tag, "_tick_count"}, tick_count, exp_ticks);
      chk({tag, "_snap_avail"}, 32'(snap_q.size() != 0), 1);
      if (snap_q.size() != 0) chk({tag, "_snapshot"}, snapshot, snap_q.pop_front());
      @(negedge clk);
      chk({tag, "_valid_1cyc"}, 32'(snapshot_valid), 0);
      chk({tag, "_pulse_1cyc"}, 32'(tick_pulse), 0);
   endtask

   initial begin
      reset_n = 0; start = 0; stop = 0; period_in = 0; continuous = 0; force_rd = 0;
      exp_ticks = 0;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(avm_chipselect), 0);
      chk("rst_write_n", 32'(avm_write_n), 1);
      chk("rst_addr", 32'(avm_address), 0);
      chk("rst_wdata", 32'(avm_writedata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ticks", tick_count, 0);
      chk("rst_snapshot", snapshot, 0);
      chk("rst_err", 32'(err), 0);
      reset_n = 1;
      @(negedge clk);

      push_prog(32'd49999, 1'b1);
      pulse_start(32'd49999, 1'b1);
      repeat (12) @(negedge clk);
      chk("prog_busy", 32'(busy), 1);
      chk("prog_drained", 32'(exp_q.size()), 0);
      push_bus(3'd1, 1'b1, 16'h0008);
      pulse_stop();
      wait_for(1, "run_stop_idle", 20);

      exp_ticks = 0;
      push_prog(32'd30, 1'b1);
      push_service();
      pulse_start(32'd30, 1'b1);
      wait_for(0, "svc1_wait", 200);
      check_upd("svc1");
      force_rd = 1;
      push_service();
      wait_for(0, "svc2_wait", 200);
      check_upd("svc2");
      force_rd = 0;
      push_service();
      wait_for(2, "svc3_rdl", 200);
      push_bus(3'd1, 1'b1, 16'h0008);
      pulse_stop();
      wait_for(0, "svc3_wait", 50);
      check_upd("svc3");
      wait_for(1, "svc3_idle", 50);
      repeat (40) @(negedge clk);
      chk("stop_irq_low", 32'(timer_irq), 0);
      chk("stop_drained", 32'(exp_q.size()), 0);

      exp_ticks = 0;
      push_prog(32'd10, 1'b0);
      push_service();
      pulse_start(32'd10, 1'b0);
      wait_for(0, "oneshot_wait", 200);
      check_upd("oneshot");
      wait_for(1, "oneshot_idle", 20);
      repeat (30) @(negedge clk);
      chk("oneshot_busy", 32'(busy), 0);
      chk("oneshot_drained", 32'(exp_q.size()), 0);

      pulse_start(32'd0, 1'b1);
      chk("zero_err", 32'(err), 1);
      chk("zero_busy", 32'(busy), 0);
      @(negedge clk);
      chk("zero_err_1cyc", 32'(err), 0);
      repeat (5) @(negedge clk);
      chk("zero_no_bus", 32'(exp_q.size()), 0);

      push_prog(32'd30, 1'b1);
      push_service();
      pulse_start(32'd30, 1'b1);
      repeat (12) @(negedge clk);
      force dut.tick_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.tick_count;
      exp_ticks = 32'hFFFF_FFFF;
      wait_for(0, "wrap_wait", 200);
      check_upd("wrap");
      push_bus(3'd1, 1'b1, 16'h0008);
      pulse_stop();
      wait_for(1, "wrap_idle", 30);

      push_bus(3'd2, 1'b1, 16'd30);
      push_bus(3'd3, 1'b1, 16'd0);
      pulse_start(32'd30, 1'b1);
      wait_for(3, "rst_mid_wrph", 30);
      #2 reset_n = 0;
      #1;
      chk("mid_rst_cs", 32'(avm_chipselect), 0);
      chk("mid_rst_write_n", 32'(avm_write_n), 1);
      chk("mid_rst_addr", 32'(avm_address), 0);
      chk("mid_rst_wdata", 32'(avm_writedata), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ticks", tick_count, 0);
      chk("mid_rst_snapshot", snapshot, 0);
      chk("mid_rst_valid", 32'(snapshot_valid), 0);
      @(negedge clk) reset_n = 1;
      repeat (10) @(negedge clk);
      chk("mid_rst_idle", 32'(busy), 0);
      chk("final_drained", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
